// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared state type and constants for the Avalon memory arbiter
package mips_mem_pkg;
    typedef enum logic [1:0] {IDLE, WRITE, READ} arb_state_t;
    localparam logic [3:0]  BE_WORD         = 4'hF;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;
endpackage

// File: rtl/mips_stall_timer.sv
// mips_stall_timer: saturating stall counter with sticky timeout flag
// Ports: clk, rst (async active-low); clear restarts the count; stall counts one
//        cycle; enable gates the flag; err is the sticky timeout flag
module mips_stall_timer #(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic stall,
    input  logic enable,
    output logic err
);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next;
    assign w_next = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
    // The flag is raised on the edge where the count reaches the limit, so it is
    // visible immediately after the last allowed stall cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            err   <= 1'b0;
        end else begin
            if (clear)
                r_cnt <= '0;
            else if (stall)
                r_cnt <= w_next;
            if (enable && stall && !clear && w_next == CNT_W'(TIMEOUT_CYCLES))
                err <= 1'b1;
        end
    end
endmodule

// File: rtl/mips_avalon_mem_arbiter.sv
// mips_avalon_mem_arbiter: serialises write-buffer drains and cache reads onto one Avalon-MM master
// Ports: clk, rst (async active-low); wb_* write-buffer head and its waitrequest;
//        rd_* cache read request, data and waitrequest; avm_* Avalon-MM master;
//        timeout_err sticky flag for a slave stalling too long
module mips_avalon_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_addr,
    input  logic [31:0] wb_writedata,
    input  logic [3:0]  wb_byteenable,
    input  logic        wb_write,
    output logic        wb_waitrequest,
    input  logic [31:0] rd_addr,
    input  logic        rd_read,
    output logic [31:0] rd_readdata,
    output logic        rd_waitrequest,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        timeout_err
);
    arb_state_t r_state;
    logic       w_start;
    logic       w_stall;
    assign w_start        = (r_state == IDLE) && (wb_write || rd_read);
    assign w_stall        = (r_state != IDLE) && avm_waitrequest;
    assign wb_waitrequest = !(r_state == WRITE && !avm_waitrequest);
    assign rd_waitrequest = !(r_state == READ && !avm_waitrequest);
    assign rd_readdata    = avm_readdata;
    // Writes win in IDLE so a read can never overtake an older buffered write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_address    <= '0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (wb_write) begin
                        avm_address    <= wb_addr & WORD_ALIGN_MASK;
                        avm_writedata  <= wb_writedata;
                        avm_byteenable <= wb_byteenable;
                        avm_write      <= 1'b1;
                        r_state        <= WRITE;
                    end else if (rd_read) begin
                        avm_address    <= rd_addr & WORD_ALIGN_MASK;
                        avm_byteenable <= BE_WORD;
                        avm_read       <= 1'b1;
                        r_state        <= READ;
                    end
                end
                WRITE: begin
                    if (!avm_waitrequest) begin
                        avm_write <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                READ: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    mips_stall_timer #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_start),
        .stall  (w_stall),
        .enable (TIMEOUT_CYCLES != 0),
        .err    (timeout_err)
    );
endmodule

// File: tb/tb_mips_avalon_mem_arbiter.sv
// tb_mips_avalon_mem_arbiter: scoreboard bench for the Avalon memory arbiter
module tb_mips_avalon_mem_arbiter;
    localparam int TO = 8;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] wb_addr = '0;
    logic [31:0] wb_writedata = '0;
    logic [3:0]  wb_byteenable = '0;
    logic        wb_write = 1'b0;
    logic        wb_waitrequest;
    logic [31:0] rd_addr = '0;
    logic        rd_read = 1'b0;
    logic [31:0] rd_readdata;
    logic        rd_waitrequest;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;
    logic        timeout_err;
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } txn_t;
    txn_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   m_cnt = 0;
    logic m_err = 1'b0;
    always #5 clk = ~clk;
    mips_avalon_mem_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .wb_addr         (wb_addr),
        .wb_writedata    (wb_writedata),
        .wb_byteenable   (wb_byteenable),
        .wb_write        (wb_write),
        .wb_waitrequest  (wb_waitrequest),
        .rd_addr         (rd_addr),
        .rd_read         (rd_read),
        .rd_readdata     (rd_readdata),
        .rd_waitrequest  (rd_waitrequest),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .timeout_err     (timeout_err)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    // Scoreboard: every completed Avalon transfer must match the oldest expected one.
    always @(negedge clk) begin
        if (rst && (avm_write || avm_read) && !avm_waitrequest) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", 32'd1, 32'd0);
            end else begin
                txn_t t;
                t = sb.pop_front();
                chk("sb_kind", {31'b0, avm_write}, {31'b0, t.wr});
                chk("sb_addr", avm_address, t.addr);
                chk("sb_be", {28'b0, avm_byteenable}, {28'b0, t.be});
                if (t.wr) begin
                    chk("sb_wdata", avm_writedata, t.data);
                    chk("sb_wb_wait", {31'b0, wb_waitrequest}, 32'd0);
                    chk("sb_rd_wait_idle", {31'b0, rd_waitrequest}, 32'd1);
                end else begin
                    chk("sb_rdata", rd_readdata, t.data);
                    chk("sb_rd_wait", {31'b0, rd_waitrequest}, 32'd0);
                    chk("sb_wb_wait_idle", {31'b0, wb_waitrequest}, 32'd1);
                end
            end
        end
    end
    task automatic run_txn(input logic wr, input logic [31:0] addr, input int stalls);
        for (int i = 0; i <= stalls; i++) begin
            avm_waitrequest = (i < stalls);
            @(negedge clk);
            chk("strobe", {31'b0, wr ? avm_write : avm_read}, 32'd1);
            chk("other_strobe", {31'b0, wr ? avm_read : avm_write}, 32'd0);
            chk("addr_hold", avm_address, addr);
            chk("terr", {31'b0, timeout_err}, {31'b0, m_err});
            if (i < stalls) begin
                chk("cli_wait", {31'b0, wr ? wb_waitrequest : rd_waitrequest}, 32'd1);
                m_cnt++;
                if (m_cnt == TO) m_err = 1'b1;
            end
            tick;
        end
        avm_waitrequest = 1'b0;
    endtask
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input int stalls);
        txn_t t;
        wb_write = 1'b1;
        wb_addr = a;
        wb_writedata = d;
        wb_byteenable = be;
        t.wr = 1'b1;
        t.addr = a & 32'hFFFF_FFFC;
        t.data = d;
        t.be = be;
        sb.push_back(t);
        @(negedge clk);
        chk("idle_gap", {30'b0, avm_write, avm_read}, 32'd0);
        tick;
        m_cnt = 0;
        run_txn(1'b1, t.addr, stalls);
        wb_write = 1'b0;
    endtask
    task automatic do_read(input logic [31:0] a, input logic [31:0] d, input int stalls);
        txn_t t;
        rd_read = 1'b1;
        rd_addr = a;
        avm_readdata = d;
        t.wr = 1'b0;
        t.addr = a & 32'hFFFF_FFFC;
        t.data = d;
        t.be = 4'hF;
        sb.push_back(t);
        @(negedge clk);
        chk("idle_gap", {30'b0, avm_write, avm_read}, 32'd0);
        tick;
        m_cnt = 0;
        run_txn(1'b0, t.addr, stalls);
        rd_read = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        repeat (2) @(negedge clk);
        chk("rst_write", {31'b0, avm_write}, 32'd0);
        chk("rst_read", {31'b0, avm_read}, 32'd0);
        chk("rst_addr", avm_address, 32'd0);
        chk("rst_wdata", avm_writedata, 32'd0);
        chk("rst_be", {28'b0, avm_byteenable}, 32'd0);
        chk("rst_terr", {31'b0, timeout_err}, 32'd0);
        chk("rst_wb_wait", {31'b0, wb_waitrequest}, 32'd1);
        chk("rst_rd_wait", {31'b0, rd_waitrequest}, 32'd1);
        tick;
        rst = 1'b1;
        wb_write = 1'b1;
        wb_addr = 32'h0000_3000;
        wb_writedata = 32'h1111_1111;
        wb_byteenable = 4'hF;
        avm_waitrequest = 1'b1;
        tick;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rmw_write", {31'b0, avm_write}, 32'd1);
            chk("rmw_wb_wait", {31'b0, wb_waitrequest}, 32'd1);
            tick;
        end
        #2 rst = 1'b0;
        #1;
        chk("rmw_write_drop", {31'b0, avm_write}, 32'd0);
        chk("rmw_addr_clr", avm_address, 32'd0);
        chk("rmw_wb_wait", {31'b0, wb_waitrequest}, 32'd1);
        wb_write = 1'b0;
        avm_waitrequest = 1'b0;
        m_cnt = 0;
        m_err = 1'b0;
        tick;
        rst = 1'b1;
        @(negedge clk);
        chk("rmw_idle", {30'b0, avm_write, avm_read}, 32'd0);
        chk("rmw_no_complete", {31'b0, wb_waitrequest}, 32'd1);
        tick;
        do_write(32'h0000_1007, 32'hDEAD_BEEF, 4'b0110, 0);
        @(negedge clk);
        chk("single_write_drop", {31'b0, avm_write}, 32'd0);
        tick;
        do_read(32'h0000_2000, 32'hCAFE_0001, 4);
        rd_read = 1'b1;
        rd_addr = 32'h0000_4008;
        avm_readdata = 32'h0;
        do_write(32'h0000_5000, 32'hA5A5_0001, 4'hF, 0);
        do_write(32'h0000_5004, 32'hA5A5_0002, 4'b1000, 2);
        do_read(32'h0000_400B, 32'h1234_5678, 0);
        do_write(32'h0000_6000, 32'h0BAD_F00D, 4'h0, 1);
        do_write(32'h0000_7000, 32'h7000_0000, 4'hF, 0);
        do_write(32'h0000_7004, 32'h7000_0004, 4'hF, 0);
        do_write(32'h0000_7008, 32'h7000_0008, 4'hF, 0);
        @(negedge clk);
        chk("pre_timeout_terr", {31'b0, timeout_err}, 32'd0);
        tick;
        do_write(32'h0000_8000, 32'h8888_8888, 4'hF, 11);
        @(negedge clk);
        chk("timeout_sticky", {31'b0, timeout_err}, 32'd1);
        tick;
        do_read(32'h0000_9002, 32'h9999_0000, 1);
        repeat (2) tick;
        chk("timeout_after", {31'b0, timeout_err}, 32'd1);
        chk("sb_drain", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_avalon_mem_arbiter.md
Name: mips_avalon_mem_arbiter

Overview:
- Downstream of the cache write buffer. Merges two requesters onto the single Avalon-MM master port to memory:
  - the write buffer's drain stream (write_addr, write_data, write_byteenable, write_writeenable, waitrequest);
  - the cache's refill/uncached read requests.
- Serialises transactions, one outstanding at a time.
- Gives write-buffer drains priority so that reads never overtake older buffered writes.
- Flags memory that stalls too long.

Parameters:
- TIMEOUT_CYCLES, 1024: consecutive avm_waitrequest-high cycles in one transaction before timeout_err is set; 0 disables the check.
- CNT_W, 16: width of the stall counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- wb_addr  in  32  write-buffer head address
- wb_writedata  in  32  write-buffer head data
- wb_byteenable  in  4  write-buffer head byte enables
- wb_write  in  1  write-buffer head valid; held until accepted
- wb_waitrequest  out  1  low only in the cycle the write completes
- rd_addr  in  32  cache read address
- rd_read  in  1  cache read request; held until accepted
- rd_readdata  out  32  read data, valid when rd_read && !rd_waitrequest
- rd_waitrequest  out  1  low only in the cycle the read completes
- avm_address  out  32  Avalon address, word aligned
- avm_read  out  1  Avalon read strobe
- avm_write  out  1  Avalon write strobe
- avm_writedata  out  32  Avalon write data
- avm_byteenable  out  4  Avalon byte enables
- avm_readdata  in  32  Avalon read data
- avm_waitrequest  in  1  Avalon slave stall
- timeout_err  out  1  sticky stall-timeout flag

Behaviour:
- **States:** IDLE, WRITE, READ.
- **Registered outputs:** all avm_* outputs and timeout_err are registered.
- **Combinational outputs:**
  - wb_waitrequest = !(state==WRITE && !avm_waitrequest).
  - rd_waitrequest = !(state==READ && !avm_waitrequest).
  - rd_readdata = avm_readdata, passed through.
- **Reset (rst low, asynchronous):**
  - state=IDLE.
  - avm_read=0, avm_write=0.
  - avm_address=0, avm_writedata=0, avm_byteenable=0.
  - stall counter=0, timeout_err=0.
  - A transaction in flight at reset is abandoned; the strobes drop immediately and nothing is replayed.
- **IDLE:**
  - If wb_write: latch avm_address={wb_addr[31:2],2'b00}, avm_writedata=wb_writedata, avm_byteenable=wb_byteenable; set avm_write=1; go to WRITE.
  - Else if rd_read: latch avm_address={rd_addr[31:2],2'b00}, avm_byteenable=4'hF; set avm_read=1; go to READ.
  - Simultaneous requests: the write always wins. The read waits until the write buffer is empty (wb_write low in IDLE).
- **WRITE / READ:**
  - Hold all avm_* outputs stable while avm_waitrequest=1.
  - The transaction completes in the first cycle with avm_waitrequest=0.
  - In that cycle the matching client waitrequest is low. At the clock edge, deassert the strobe and return to IDLE.
- **Latency and throughput:**
  - Request seen in IDLE at cycle N → strobe asserted at cycle N+1 → earliest completion at cycle N+1.
  - There is one mandatory IDLE cycle between transactions, because the client still presents its old request in the completion cycle. Peak rate is one transaction per 2 cycles.
- **Inputs outside the owning state:** wb_* and rd_* are ignored outside IDLE except by the state owning them. A client dropping its request mid-transaction does not abort the bus cycle.
- **Byte enables:** wb_byteenable=4'h0 is still issued as a write. Filtering empty writes is the write buffer's job.
- **Stall counter:**
  - Cleared on entry to WRITE/READ.
  - Increments on each cycle with avm_waitrequest=1, saturating at its maximum.
  - When it equals TIMEOUT_CYCLES (TIMEOUT_CYCLES≠0), set timeout_err.
  - timeout_err is cleared only by reset. The transaction keeps waiting; there is no forced abort.

Decomposition:
- **Package mips_mem_pkg:**
  - state enum arb_state_t {IDLE, WRITE, READ};
  - constant BE_WORD = 4'hF;
  - constant WORD_ALIGN_MASK = 32'hFFFF_FFFC.
- **Sub-module mips_stall_timer:** holds the stall counter and sticky flag, with inputs clear, stall and enable, and output err. The rest of the block stays in a single module.

Test Plan:
- **Reset mid-write:** assert wb_write, hold avm_waitrequest=1 for 3 cycles, then pulse rst low → avm_write=0 immediately, state IDLE, no completion cycle seen by the write buffer.
- **Single write:** wb_write, wb_addr=32'h0000_1007, wb_writedata=32'hDEADBEEF, wb_byteenable=4'b0110, avm_waitrequest=0 → next cycle avm_write=1, avm_address=32'h0000_1004, avm_byteenable=4'b0110, wb_waitrequest=0; the cycle after that avm_write=0.
- **Stalled read:** rd_read, rd_addr=32'h0000_2000, avm_waitrequest high for 4 cycles then low with avm_readdata=32'hCAFE0001 → avm_read held 5 cycles with stable address, rd_waitrequest low only in the 5th, rd_readdata=32'hCAFE0001.
- **Simultaneous requests:** wb_write and rd_read both high in IDLE → write issued first; read issued only after wb_write drops.
- **Back-to-back drain:** 3 queued writes, avm_waitrequest=0 → avm_write pattern 1,0,1,0,1 over 5 cycles, addresses in order.
- **Timeout:** TIMEOUT_CYCLES=8, avm_waitrequest stuck high → timeout_err rises exactly after the 8th stalled cycle and stays high after the transaction later completes.
